// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_unit
// Purpose : Pipeline stall/flush control for load-use, memory-wait and
//           taken-branch hazards, with freeze watchdog and stall counter.
// Rev     : 1.0
// ============================================================================
module hazard_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_read,
  input  logic             ex_en,
  input  logic [2:0]       ex_rdst,
  input  logic [2:0]       id_rsrc1,
  input  logic [2:0]       id_rsrc2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_br_taken,
  input  logic             me_mem_req,
  input  logic             mem_ready,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_TOUT = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              err_set;
  logic              freeze_raw;
  logic              load_use;

  assign freeze_raw = me_mem_req & ~mem_ready;
  assign load_use   = ex_mem_read & ~ex_en &
                      ((id_use1 & (id_rsrc1 == ex_rdst)) |
                       (id_use2 & (id_rsrc2 == ex_rdst)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_set   = 1'b0;
    case (state)
      S_RUN: begin
        if (freeze_raw) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!freeze_raw) begin
          state_nxt = S_RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt = S_TOUT;
          err_set   = 1'b1;
        end else begin
          wcnt_nxt  = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        // Timeout cycle: one unfrozen cycle lets the pipeline drop the access.
        state_nxt = S_RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    freeze      = freeze_raw & (state != S_TOUT);
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (freeze) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (err_set) begin
      mem_err <= 1'b1;
    end else if (err_clr) begin
      mem_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
    end else if (pc_stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
